// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit: request opcodes,
//               FSM states and small opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Request opcodes; 101-111 are not defined and are answered with an error.
  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_SW  = 3'b001,
    OP_LB  = 3'b010,
    OP_LBU = 3'b011,
    OP_SB  = 3'b100
  } op_e;

  // Transaction FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // True for any opcode the unit knows how to execute.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'(OP_SB));
  endfunction

  // Word accesses must start on an even byte address.
  function automatic logic op_is_word(input logic [2:0] op);
    return (op == 3'(OP_LW)) || (op == 3'(OP_SW));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : lsu_byte_lane
// Description : Combinational byte lane helper. Extracts the addressed byte
//               of a RAM word (sign- and zero-extended) and builds the word
//               with that byte replaced for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_lane #(
  parameter int DWIDTH = 16
) (
  input  logic [DWIDTH-1:0] word_i,
  input  logic              lane_i,
  input  logic [7:0]        byte_i,
  output logic [DWIDTH-1:0] lb_o,
  output logic [DWIDTH-1:0] lbu_o,
  output logic [DWIDTH-1:0] merged_o
);

  logic [7:0] w_sel;

  // Select the addressed lane, extend it, and splice the store byte in.
  always_comb begin
    w_sel    = lane_i ? word_i[15:8] : word_i[7:0];
    lb_o     = {{(DWIDTH-8){w_sel[7]}}, w_sel};
    lbu_o    = {{(DWIDTH-8){1'b0}}, w_sel};
    merged_o = word_i;
    if (lane_i) begin
      merged_o[15:8] = byte_i;
    end else begin
      merged_o[7:0]  = byte_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Single-outstanding load/store unit in front of a synchronous
//               RAM. Supports word and byte loads/stores; byte stores are a
//               read-modify-write of the containing word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_req_op,
  input  logic [AWIDTH:0]   i_req_addr,
  input  logic [DWIDTH-1:0] i_req_wdata,
  input  logic [3:0]        i_req_tag,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DWIDTH-1:0] o_resp_data,
  output logic [3:0]        o_resp_tag,
  output logic              o_resp_err,
  output logic              o_ram_rd,
  output logic              o_ram_wr,
  output logic [AWIDTH-1:0] o_ram_raddr,
  output logic [AWIDTH-1:0] o_ram_waddr,
  output logic [DWIDTH-1:0] o_ram_wdata,
  input  logic [DWIDTH-1:0] i_ram_rdata
);

  state_e            state_q;
  logic [2:0]        op_q;
  logic [AWIDTH:0]   addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              resp_valid_q;
  logic [DWIDTH-1:0] resp_data_q;
  logic [3:0]        resp_tag_q;
  logic              resp_err_q;

  logic [DWIDTH-1:0] w_lb;
  logic [DWIDTH-1:0] w_lbu;
  logic [DWIDTH-1:0] w_merged;

  lsu_byte_lane #(
    .DWIDTH (DWIDTH)
  ) u_byte_lane (
    .word_i   (i_ram_rdata),
    .lane_i   (addr_q[0]),
    .byte_i   (wdata_q[7:0]),
    .lb_o     (w_lb),
    .lbu_o    (w_lbu),
    .merged_o (w_merged)
  );

  // Transaction FSM with registered response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid) begin
            op_q       <= i_req_op;
            addr_q     <= i_req_addr;
            wdata_q    <= i_req_wdata;
            resp_tag_q <= i_req_tag;
            if (!op_is_legal(i_req_op) || (op_is_word(i_req_op) && i_req_addr[0])) begin
              // Rejected without touching the RAM.
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= '0;
              resp_err_q   <= 1'b1;
            end else if (i_req_op == 3'(OP_SW)) begin
              state_q <= ST_WR;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          state_q <= ST_CAP;
        end
        ST_CAP: begin
          case (op_q)
            3'(OP_SB): begin
              wdata_q <= w_merged;
              state_q <= ST_WR;
            end
            3'(OP_LW), 3'(OP_LB), 3'(OP_LBU): begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_data_q  <= (op_q == 3'(OP_LW)) ? i_ram_rdata :
                              (op_q == 3'(OP_LB)) ? w_lb : w_lbu;
            end
            default: begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
            end
          endcase
        end
        ST_WR: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_data_q  <= '0;
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Handshake and RAM strobes come from the state register only; reset masks them at once.
  always_comb begin
    o_req_ready = !rst && (state_q == ST_IDLE);
    o_ram_rd    = !rst && (state_q == ST_RD);
    o_ram_wr    = !rst && (state_q == ST_WR);
    o_ram_raddr = addr_q[AWIDTH:1];
    o_ram_waddr = addr_q[AWIDTH:1];
    o_ram_wdata = wdata_q;
  end

  assign o_resp_valid = resp_valid_q;
  assign o_resp_data  = resp_data_q;
  assign o_resp_tag   = resp_tag_q;
  assign o_resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Self-checking bench for lsu with a behavioural synchronous
//               RAM, a reference memory model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    tag;
    logic          err;
    int            lat;
    int            rd;
    int            wr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [2:0]    i_req_op = '0;
  logic [AW:0]   i_req_addr = '0;
  logic [DW-1:0] i_req_wdata = '0;
  logic [3:0]    i_req_tag = '0;
  logic          o_resp_valid;
  logic          i_resp_ready = 1'b0;
  logic [DW-1:0] o_resp_data;
  logic [3:0]    o_resp_tag;
  logic          o_resp_err;
  logic          o_ram_rd;
  logic          o_ram_wr;
  logic [AW-1:0] o_ram_raddr;
  logic [AW-1:0] o_ram_waddr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;

  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  int            overlap_cnt = 0;
  int            rst_strobe_cnt = 0;
  logic [AW-1:0] last_raddr = '0;
  logic [AW-1:0] last_waddr = '0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  lsu #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_op     (i_req_op),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_tag    (i_req_tag),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_data  (o_resp_data),
    .o_resp_tag   (o_resp_tag),
    .o_resp_err   (o_resp_err),
    .o_ram_rd     (o_ram_rd),
    .o_ram_wr     (o_ram_wr),
    .o_ram_raddr  (o_ram_raddr),
    .o_ram_waddr  (o_ram_waddr),
    .o_ram_wdata  (o_ram_wdata),
    .i_ram_rdata  (i_ram_rdata)
  );

  // Synchronous RAM with registered read data and a bench preload port.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (o_ram_rd) begin
      i_ram_rdata <= mem[o_ram_raddr];
      rd_cnt      <= rd_cnt + 1;
      last_raddr  <= o_ram_raddr;
    end
    if (o_ram_wr) begin
      mem[o_ram_waddr] <= o_ram_wdata;
      wr_cnt           <= wr_cnt + 1;
      last_waddr       <= o_ram_waddr;
    end
  end

  // Strobe protocol monitors.
  always @(negedge clk) begin
    if (o_ram_rd && o_ram_wr) overlap_cnt <= overlap_cnt + 1;
    if (rst && (o_ram_rd || o_ram_wr)) rst_strobe_cnt <= rst_strobe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one request; updates the reference memory for stores.
  function automatic exp_t model(input logic [2:0] op, input logic [AW:0] addr,
                                 input logic [DW-1:0] wd, input logic [3:0] tag);
    exp_t          e;
    logic [DW-1:0] w;
    logic [7:0]    b;
    w = ref_mem[addr[AW:1]];
    b = addr[0] ? w[15:8] : w[7:0];
    e.tag = tag; e.err = 1'b0; e.data = '0; e.rd = 0; e.wr = 0; e.lat = 1;
    if (op > 3'd4 || ((op == 3'd0 || op == 3'd1) && addr[0])) begin
      e.err = 1'b1;
    end else begin
      case (op)
        3'd0: begin e.data = w; e.lat = 3; e.rd = 1; end
        3'd2: begin e.data = {{8{b[7]}}, b}; e.lat = 3; e.rd = 1; end
        3'd3: begin e.data = {8'h00, b}; e.lat = 3; e.rd = 1; end
        3'd1: begin ref_mem[addr[AW:1]] = wd; e.lat = 2; e.wr = 1; end
        default: begin
          if (addr[0]) w[15:8] = wd[7:0]; else w[7:0] = wd[7:0];
          ref_mem[addr[AW:1]] = w; e.lat = 4; e.rd = 1; e.wr = 1;
        end
      endcase
    end
    return e;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one request, wait for its response, compare against the scoreboard,
  // optionally stall the response for 'hold' cycles, then complete the handshake.
  task automatic send(input logic [2:0] op, input logic [AW:0] addr,
                      input logic [DW-1:0] wd, input logic [3:0] tag, input int hold);
    exp_t          e;
    int            lat;
    int            rd0;
    int            wr0;
    int            waitc;
    logic [DW-1:0] d_hold;
    logic [3:0]    t_hold;
    logic          e_hold;
    sb_q.push_back(model(op, addr, wd, tag));
    @(negedge clk);
    waitc = 0;
    while (!o_req_ready && waitc < 20) begin @(negedge clk); waitc++; end
    if (!o_req_ready) chk("req_ready_timeout", 32'(o_req_ready), 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    i_req_valid = 1'b1; i_req_op = op; i_req_addr = addr; i_req_wdata = wd; i_req_tag = tag;
    @(posedge clk); #1;
    i_req_valid = 1'b0; i_req_op = 3'($urandom); i_req_addr = 9'($urandom);
    lat = 1;
    while (!o_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    e = sb_q.pop_front();
    if (!o_resp_valid) begin
      chk("resp_timeout", 32'(o_resp_valid), 32'd1);
      return;
    end
    chk("latency", 32'(lat), 32'(e.lat));
    chk("resp_data", 32'(o_resp_data), 32'(e.data));
    chk("resp_tag", 32'(o_resp_tag), 32'(e.tag));
    chk("resp_err", 32'(o_resp_err), 32'(e.err));
    chk("ram_rd_count", 32'(rd_cnt - rd0), 32'(e.rd));
    chk("ram_wr_count", 32'(wr_cnt - wr0), 32'(e.wr));
    if (e.rd == 1) chk("ram_raddr", 32'(last_raddr), 32'(addr[AW:1]));
    if (e.wr == 1) chk("ram_waddr", 32'(last_waddr), 32'(addr[AW:1]));
    chk("req_ready_in_resp", 32'(o_req_ready), 32'd0);
    d_hold = o_resp_data; t_hold = o_resp_tag; e_hold = o_resp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(o_resp_valid), 32'd1);
      chk("bp_data", 32'(o_resp_data), 32'(d_hold));
      chk("bp_tag", 32'(o_resp_tag), 32'(t_hold));
      chk("bp_err", 32'(o_resp_err), 32'(e_hold));
      chk("bp_req_ready", 32'(o_req_ready), 32'd0);
    end
    i_resp_ready = 1'b1;
    @(posedge clk); #1;
    i_resp_ready = 1'b0;
    chk("resp_valid_after_hs", 32'(o_resp_valid), 32'd0);
    chk("req_ready_after_hs", 32'(o_req_ready), 32'd1);
    chk("mem_word", 32'(mem[addr[AW:1]]), 32'(ref_mem[addr[AW:1]]));
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = 'x;

    // Reset and registered output state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_rd", 32'(o_ram_rd), 32'd0);
    chk("rst_ram_wr", 32'(o_ram_wr), 32'd0);
    chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("rst_resp_data", 32'(o_resp_data), 32'd0);
    chk("rst_resp_tag", 32'(o_resp_tag), 32'd0);
    chk("rst_resp_err", 32'(o_resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", 32'(o_req_ready), 32'd1);

    for (int i = 0; i < 16; i++) preload(8'(i), 16'($urandom));
    preload(8'h05, 16'hA53C);

    // Directed byte/word loads on word 0x05.
    send(3'b010, 9'h00B, 16'h0000, 4'd3, 0);   // LB  -> 0xFFA5
    send(3'b011, 9'h00A, 16'h0000, 4'd4, 0);   // LBU -> 0x003C
    send(3'b000, 9'h00A, 16'h0000, 4'd5, 0);   // LW  -> 0xA53C
    send(3'b010, 9'h00A, 16'h0000, 4'd6, 0);   // LB lane 0 positive -> 0x003C

    // Byte store read-modify-write: 0x05 becomes 0x773C.
    send(3'b100, 9'h00B, 16'h0077, 4'd7, 0);
    chk("sb_word_value", 32'(mem[5]), 32'h773C);

    // Error paths.
    send(3'b001, 9'h003, 16'h1234, 4'd8, 0);   // misaligned SW
    send(3'b111, 9'h004, 16'h1234, 4'd9, 0);   // illegal op
    send(3'b000, 9'h001, 16'h0000, 4'd10, 0);  // misaligned LW

    // Aligned word store, then backpressured read-back followed immediately by another request.
    send(3'b001, 9'h00C, 16'hBEEF, 4'd11, 0);
    send(3'b000, 9'h00C, 16'h0000, 4'd12, 5);
    send(3'b011, 9'h00D, 16'h0000, 4'd13, 0);

    // Random mix over the preloaded words, including illegal ops and odd addresses.
    for (int i = 0; i < 16; i++) begin
      send(3'($urandom_range(0, 7)), 9'($urandom_range(0, 31)), 16'($urandom),
           4'(i), i % 3);
    end

    // Reset while a byte store sits in CAP: no write, no response.
    wr0 = wr_cnt;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_op = 3'b100; i_req_addr = 9'h00A; i_req_wdata = 16'h00EE; i_req_tag = 4'd1;
    @(posedge clk); #1;           // accepted, now in RD
    i_req_valid = 1'b0;
    @(posedge clk); #1;           // now in CAP
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstcap_ram_wr", 32'(o_ram_wr), 32'd0);
    chk("rstcap_resp_valid", 32'(o_resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstcap_idle", 32'(o_req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("rstcap_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("rstcap_mem", 32'(mem[5]), 32'(ref_mem[5]));
    chk("rstcap_no_resp", 32'(o_resp_valid), 32'd0);

    // Follow-up request proves the unit recovered.
    send(3'b000, 9'h00A, 16'h0000, 4'd2, 0);

    chk("rd_wr_overlap", 32'(overlap_cnt), 32'd0);
    chk("strobe_during_rst", 32'(rst_strobe_cnt), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
